// File: rtl/mem_ctrl.sv
// Access sequencer for the LC-3 MAR/MDR/RAM path: turns a request/response
// handshake into ordered ldMAR/ldMDR/selMDR/memWE strobes and bus drive.
module mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_rdata,
  input  logic [15:0] mdr_in,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        memWE
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MAR   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RDMDR = 3'd3;
  localparam logic [2:0] S_WRMDR = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          we_q;
  logic [DW-1:0] addr_q, wdata_q, addr_nxt;
  logic          accept;
  logic          rd_resp, rd_resp_nxt;

  logic          req_ready_nxt, rsp_valid_nxt, bus_drive_nxt;
  logic          ldmar_nxt, ldmdr_nxt, selmdr_nxt, memwe_nxt;
  logic [DW-1:0] bus_out_nxt;

  assign accept   = (state == S_IDLE) && req_valid;
  assign addr_nxt = accept ? req_addr : addr_q;

  // Next state, wait counter and the output values for the state being entered
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    req_ready_nxt = 1'b0;
    rsp_valid_nxt = 1'b0;
    bus_drive_nxt = 1'b0;
    bus_out_nxt   = '0;
    ldmar_nxt     = 1'b0;
    ldmdr_nxt     = 1'b0;
    selmdr_nxt    = 1'b0;
    memwe_nxt     = 1'b0;
    rd_resp_nxt   = 1'b0;

    case (state)
      S_IDLE:  if (req_valid) state_nxt = S_MAR;
      S_MAR: begin
        if (we_q) begin
          state_nxt = S_WRMDR;
        end else begin
          state_nxt = S_WAIT;
          cnt_nxt   = CW'(WAIT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RDMDR;
        else           cnt_nxt   = cnt - CW'(1);
      end
      S_RDMDR: state_nxt = S_RESP;
      S_WRMDR: state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    case (state_nxt)
      S_IDLE:  req_ready_nxt = 1'b1;
      S_MAR: begin
        bus_drive_nxt = 1'b1;
        bus_out_nxt   = addr_nxt;
        ldmar_nxt     = 1'b1;
      end
      S_RDMDR: begin
        selmdr_nxt = 1'b1;
        ldmdr_nxt  = 1'b1;
      end
      S_WRMDR: begin
        bus_drive_nxt = 1'b1;
        bus_out_nxt   = wdata_q;
        ldmdr_nxt     = 1'b1;
      end
      S_WRITE: memwe_nxt = 1'b1;
      S_RESP: begin
        rsp_valid_nxt = 1'b1;
        rd_resp_nxt   = ~we_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      bus_drive <= 1'b0;
      bus_out   <= '0;
      ldMAR     <= 1'b0;
      ldMDR     <= 1'b0;
      selMDR    <= 1'b0;
      memWE     <= 1'b0;
      rd_resp   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      req_ready <= req_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      bus_drive <= bus_drive_nxt;
      bus_out   <= bus_out_nxt;
      ldMAR     <= ldmar_nxt;
      ldMDR     <= ldmdr_nxt;
      selMDR    <= selmdr_nxt;
      memWE     <= memwe_nxt;
      rd_resp   <= rd_resp_nxt;
    end
  end

  // MDR only settles on the edge that enters RESP, so read data is passed through
  assign rsp_rdata = rd_resp ? mdr_in : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (WAIT_CYCLES 1 and 4), each with a MAR/MDR/RAM
// model, driven by directed and random transactions against a word-memory model.
module tb_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid [2];
  logic        req_we    [2];
  logic [15:0] req_addr  [2];
  logic [15:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_rdata [2];
  logic [15:0] bus_out   [2];
  logic        bus_drive [2];
  logic        ld_mar    [2];
  logic        ld_mdr    [2];
  logic        sel_mdr   [2];
  logic        mem_we    [2];

  int vectors;
  int miscompares;
  logic [15:0] ref_mem [int];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [15:0] mar, mdr, ram_q, bus;
    logic [15:0] ram [65536];

    mem_ctrl #(.WAIT_CYCLES(k == 0 ? 1 : 4)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid[k]),
      .req_we    (req_we[k]),
      .req_addr  (req_addr[k]),
      .req_wdata (req_wdata[k]),
      .req_ready (req_ready[k]),
      .rsp_valid (rsp_valid[k]),
      .rsp_ready (rsp_ready[k]),
      .rsp_rdata (rsp_rdata[k]),
      .mdr_in    (mdr),
      .bus_out   (bus_out[k]),
      .bus_drive (bus_drive[k]),
      .ldMAR     (ld_mar[k]),
      .ldMDR     (ld_mdr[k]),
      .selMDR    (sel_mdr[k]),
      .memWE     (mem_we[k])
    );

    assign bus = bus_drive[k] ? bus_out[k] : 16'h0000;

    initial begin
      mar = '0;
      mdr = '0;
      ram_q = '0;
      for (int i = 0; i < 65536; i++) ram[i] = '0;
    end

    // Memory block: MAR, MDR with bus/RAM mux, RAM with one-cycle registered read
    always @(posedge clk) begin
      if (ld_mar[k]) mar <= bus;
      ram_q <= ram[mar];
      if (ld_mdr[k]) mdr <= sel_mdr[k] ? ram_q : bus;
      if (mem_we[k]) ram[mar] <= mdr;
    end
  end

  function automatic logic [38:0] obs(input int k);
    return {req_ready[k], rsp_valid[k], ld_mar[k], ld_mdr[k], sel_mdr[k], mem_we[k],
            bus_drive[k], bus_out[k], rsp_rdata[k]};
  endfunction

  function automatic logic [38:0] ev(input bit rr, input bit rv, input bit lm, input bit ld,
                                     input bit sm, input bit mw, input bit bd,
                                     input logic [15:0] bo, input logic [15:0] rd);
    return {rr, rv, lm, ld, sm, mw, bd, bo, rd};
  endfunction

  task automatic chk(input string tag, input logic [38:0] o, input logic [38:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (rr rv lm ld sm we bd | bus | rdata)", tag, o, e);
    end
  endtask

  // One complete transaction on instance k, checked cycle by cycle
  task automatic txn(input int k, input bit we, input logic [15:0] addr,
                     input logic [15:0] wdata, input int stall, input bit busy);
    int w, resp_c, key;
    logic [15:0] exp_rd;
    w      = (k == 0) ? 1 : 4;
    resp_c = we ? 4 : w + 3;
    key    = k * 65536 + int'(addr);
    exp_rd = we ? 16'h0000 : (ref_mem.exists(key) ? ref_mem[key] : 16'h0000);

    @(negedge clk);
    chk($sformatf("idle_i%0d", k), obs(k), ev(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    rsp_ready[k] = 1'b0;
    @(posedge clk);
    #1;
    req_valid[k] = busy;
    req_we[k]    = ~we;
    req_addr[k]  = 16'($urandom);
    req_wdata[k] = 16'($urandom);

    for (int c = 1; c < resp_c; c++) begin
      bit lm, wm, rm, mw;
      logic [15:0] bo;
      @(negedge clk);
      lm = (c == 1);
      wm = we && (c == 2);
      rm = !we && (c == w + 2);
      mw = we && (c == 3);
      bo = lm ? addr : (wm ? wdata : 16'h0000);
      chk($sformatf("i%0d_%s_%h_cyc%0d", k, we ? "wr" : "rd", addr, c), obs(k),
          ev(0, 0, lm, wm | rm, rm, mw, lm | wm, bo, 16'h0));
    end

    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      chk($sformatf("i%0d_resp_%h_s%0d", k, addr, s), obs(k),
          ev(0, 1, 0, 0, 0, 0, 0, 16'h0, exp_rd));
      if (s == stall) rsp_ready[k] = 1'b1;
    end

    @(negedge clk);
    chk($sformatf("i%0d_done_%h", k, addr), obs(k), ev(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    rsp_ready[k] = 1'b0;
    req_valid[k] = 1'b0;
    if (we) ref_mem[key] = wdata;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b1;
      req_we[k]    = 1'b0;
      req_addr[k]  = 16'h0000;
      req_wdata[k] = 16'h0000;
      rsp_ready[k] = 1'b0;
    end

    // Reset held two cycles with a pending request
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        chk($sformatf("reset_c%0d_i%0d", r, k), obs(k), ev(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    end
    reset = 1'b0;
    req_valid[0] = 1'b0;
    req_valid[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      chk($sformatf("post_reset_i%0d", k), obs(k), ev(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));

    // Directed: write, read-back, stalled/busy read, wait states
    txn(0, 1'b1, 16'h3000, 16'h1234, 0, 1'b0);
    txn(0, 1'b0, 16'h3000, 16'h0000, 0, 1'b0);
    txn(0, 1'b0, 16'h3000, 16'h0000, 4, 1'b1);
    txn(1, 1'b1, 16'h0000, 16'hBEEF, 0, 1'b0);
    txn(1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0);

    // Reset during WRMDR must suppress the write
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'h3001;
    req_wdata[0] = 16'hAAAA;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_mar", obs(0), ev(0, 0, 1, 0, 0, 0, 1, 16'h3001, 16'h0));
    @(negedge clk);
    chk("abort_wrmdr", obs(0), ev(0, 0, 0, 1, 0, 0, 1, 16'hAAAA, 16'h0));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_reset", obs(0), ev(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    reset = 1'b0;
    @(negedge clk);
    chk("abort_idle", obs(0), ev(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0));
    txn(0, 1'b0, 16'h3001, 16'h0000, 0, 1'b0);

    // Random traffic on both instances
    for (int n = 0; n < 40; n++) begin
      int k;
      bit we;
      logic [15:0] a;
      k  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       a = 16'h3000;
        1:       a = 16'h3001;
        2:       a = 16'h0000;
        default: a = 16'h4000 | 16'($urandom_range(0, 7));
      endcase
      txn(k, we, a, 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Access sequencer that drives the LC-3 memory subsystem (MAR, MDR, MDR mux and synchronous RAM) from a simple request/response handshake. It accepts one 16-bit read or write request at a time. It issues the `ldMAR`/`ldMDR`/`selMDR`/`memWE` strobes and drives the shared bus in the required order, then returns read data or a write acknowledge. It sits between the control FSM/datapath and the memory block and replaces ad-hoc strobe generation for MAR/MDR traffic.

## Interface
Parameters:
- `WAIT_CYCLES`, 1, cycles between MAR load and the MDR capture on reads; covers RAM read latency; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  word address.
- `req_wdata`  in  16  write data; ignored on reads.
- `req_ready`  out  1  controller can accept a request.
- `rsp_valid`  out  1  transaction complete.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  16  read data; x0000 for write responses.
- `mdr_in`  in  16  current MDR register contents.
- `bus_out`  out  16  value this block places on the shared bus.
- `bus_drive`  out  1  bus gate enable for `bus_out`.
- `ldMAR`, `ldMDR`, `selMDR`, `memWE`  out  1 each  strobes to the memory block.

## Operation
- All outputs are decoded from the state register only (Moore). No combinational path runs from a `req_*` or `rsp_ready` input to any output.
- **Request capture:** `req_we`, `req_addr` and `req_wdata` are latched on acceptance. Later input changes have no effect.
- **Default outputs:** every strobe, `bus_drive` and `selMDR` is 0. `bus_out` is x0000.
- **States:** IDLE, MAR, WAIT, RDMDR, WRMDR, WRITE, RESP.
- **IDLE**
  - `req_ready=1`.
  - On `req_valid`, move to MAR.
- **MAR**
  - `bus_drive=1`, `bus_out=addr`, `ldMAR=1`.
  - Next state is WAIT for a read, WRMDR for a write.
- **WAIT**
  - A counter loads `WAIT_CYCLES-1` on entry and decrements each cycle.
  - Move to RDMDR when the counter equals 0.
- **RDMDR**
  - `selMDR=1`, `ldMDR=1`, bus not driven.
  - Move to RESP.
- **WRMDR**
  - `bus_drive=1`, `bus_out=wdata`, `ldMDR=1`, `selMDR=0`.
  - Move to WRITE.
- **WRITE**
  - `memWE=1` for exactly one cycle. MAR and MDR are stable during this cycle.
  - Move to RESP.
- **RESP**
  - `rsp_valid=1`.
  - For reads, `rsp_rdata=mdr_in` (MDR already loaded). For writes, `rsp_rdata=x0000`.
  - Hold until `rsp_ready=1`, then move to IDLE.
- **Exclusivity invariants:**
  - `memWE` is never high in the same cycle as `ldMAR` or `ldMDR`.
  - `bus_drive` is high only in MAR and WRMDR.
  - `req_ready` is high only in IDLE.
- **Reset:** `reset` forces IDLE and clears the latched request and the counter.
  - In the cycle `reset` is high, all outputs take their default (reset) values: strobes 0, `bus_drive=0`, `bus_out=x0000`, `rsp_valid=0`, `rsp_rdata=x0000`, `req_ready=0`.
  - From the cycle after `reset` deasserts, `req_ready=1`.
  - A reset asserted before WRITE is reached guarantees no memory write for that transaction.

## Timing
- Let the request be accepted at rising edge E0. The state after E0 is MAR.
- **Read:** MAR (cycle 1), WAIT ×`WAIT_CYCLES`, RDMDR, then RESP.
  - `rsp_valid` rises `WAIT_CYCLES+2` cycles after E0 (3 with the default).
- **Write:** MAR, WRMDR, WRITE, then RESP.
  - `rsp_valid` rises 3 cycles after E0.
- **Response handshake:**
  - If `rsp_ready` is high while in RESP, the next state is IDLE.
  - A new request is accepted no sooner than one cycle after the response handshake. Maximum throughput is one transaction per `WAIT_CYCLES+4` cycles (read) or 5 cycles (write).
- **While busy:** `req_valid` is ignored and not queued, and `req_ready` stays 0.
- **Stalled response:** while `rsp_ready` is low in RESP, `rsp_valid` and `rsp_rdata` hold constant.

## Test plan
- **Reset values:** hold `reset` 2 cycles with `req_valid=1`.
  - During reset, all strobes, `bus_drive` and `rsp_valid` are 0, and `req_ready=0`.
  - `req_ready=1` in the first cycle after deassert.
- **Write:** write x3000 ← x1234 with `rsp_ready=1`.
  - Exactly one `ldMAR` cycle with `bus_out=x3000`.
  - Then one `ldMDR` cycle with `bus_out=x1234` and `selMDR=0`.
  - Then one `memWE` cycle.
  - `rsp_valid` 3 cycles after acceptance, with `rsp_rdata=x0000`.
- **Read-back:** read x3000 with the default `WAIT_CYCLES`.
  - `selMDR=ldMDR=1` in cycle 3.
  - `rsp_valid` 3 cycles after acceptance, with `rsp_rdata=x1234`.
  - `memWE` never asserted.
- **Stalled response and busy:** read with `rsp_ready=0` for 4 cycles and `req_valid` held high throughout.
  - `rsp_valid` and `rsp_rdata` hold steady while stalled.
  - `req_ready=0` throughout; no second transaction starts.
  - IDLE is reached the cycle after `rsp_ready=1`.
- **Wait states:** set `WAIT_CYCLES=4` and read x0000 after writing xBEEF there.
  - `rsp_valid` 6 cycles after acceptance, with `rsp_rdata=xBEEF`.
- **Reset mid-write:** start a write of x3001 ← xAAAA and assert `reset` in the WRMDR cycle.
  - `memWE` stays 0 throughout.
  - A subsequent read of x3001 returns the prior contents (x0000 after memory init).
